cmd_sched_mem: RTL

Parametrised timed-command scheduler memory. It stores up to DEPTH commands, each a time-stamp plus payload, and keeps a valid bit per slot. It continuously selects the earliest pending command and delivers it to the synchronisation/execution block on REQ_COMM. It sits between the MCU/SPI command interface and the sync block, and handles insertion, expiry purge, re-scan on system-time reload, and flush.

---
 rtl/cmd_sched_mem.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_sched_mem.sv
// Timed-command scheduler memory: stores time-stamped commands, purges stale ones
// and continuously presents the earliest pending command to the sync block.
module cmd_sched_mem #(
    parameter int DEPTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter int TIME_W    = 64,
    parameter int PAYLOAD_W = 274
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [TIME_W-1:0]    TIME,
    input  logic                 SYS_TIME_UPDATE,
    input  logic                 FLUSH,
    input  logic                 WR_VALID,
    input  logic [TIME_W-1:0]    WR_TIME,
    input  logic [PAYLOAD_W-1:0] WR_PAYLOAD,
    output logic                 WR_READY,
    input  logic                 REQ_COMM,
    output logic                 DATA_WR,
    output logic                 CMD_VALID,
    output logic [TIME_W-1:0]    CMD_TIME,
    output logic [PAYLOAD_W-1:0] CMD_PAYLOAD,
    output logic [AW-1:0]        CMD_ADDR,
    output logic [AW:0]          FILL_CNT,
    output logic                 FULL,
    output logic                 EXPIRED
);

    localparam int EW = TIME_W + PAYLOAD_W;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, LOAD = 2'd2, LATCH = 2'd3} state_t;

    logic [EW-1:0]        mem_r [DEPTH];
    logic [EW-1:0]        rd_data_r;
    logic [DEPTH-1:0]     valid_r;
    logic [AW:0]          fill_cnt_r;
    logic                 full_r;
    state_t               state_r;
    logic                 rescan_pend_r;
    logic                 req_pend_r;
    logic [2:0]           sys_sync_r;
    logic [AW:0]          scan_addr_r;
    logic [AW-1:0]        cmp_addr_r;
    logic                 cmp_en_r;
    logic [TIME_W-1:0]    best_time_r;
    logic [AW-1:0]        best_addr_r;
    logic                 best_found_r;
    logic                 cmd_valid_r;
    logic [TIME_W-1:0]    cmd_time_r;
    logic [PAYLOAD_W-1:0] cmd_payload_r;
    logic [AW-1:0]        cmd_addr_r;
    logic                 data_wr_r;
    logic                 expired_r;

    logic [AW-1:0]        free_idx_s;
    logic [AW-1:0]        rd_addr_s;
    logic [AW:0]          fill_next_s;
    logic [TIME_W-1:0]    rd_time_s;
    logic                 wr_ready_s, accept_s, deliver_s, go_scan_s, sys_rise_s;
    logic                 cmp_hit_s, expire_s, cand_s, better_s, cmp_last_s;

    // Lowest-index free slot for the next accepted write
    always_comb begin
        free_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = AW'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Control decode, scan comparison and fill-count next value
    always_comb begin
        rd_time_s  = rd_data_r[EW-1:PAYLOAD_W];
        sys_rise_s = sys_sync_r[1] & ~sys_sync_r[2];
        wr_ready_s = (state_r == IDLE) & ~full_r & ~(req_pend_r & cmd_valid_r) & ~FLUSH;
        accept_s   = wr_ready_s & WR_VALID;
        deliver_s  = (state_r == IDLE) & ~FLUSH & req_pend_r & cmd_valid_r;
        go_scan_s  = (state_r == IDLE) & ~FLUSH & ~deliver_s & rescan_pend_r;
        cmp_hit_s  = (state_r == SCAN) & cmp_en_r & valid_r[cmp_addr_r];
        expire_s   = cmp_hit_s & (rd_time_s < TIME) & ~FLUSH;
        cand_s     = cmp_hit_s & ~(rd_time_s < TIME);
        // strict less-than keeps the lower index on equal times
        better_s   = cand_s & (~best_found_r | (rd_time_s < best_time_r));
        cmp_last_s = (state_r == SCAN) & cmp_en_r & (cmp_addr_r == AW'(DEPTH - 1));
        if (state_r == LOAD) begin
            rd_addr_s = best_addr_r;
        end else begin
            rd_addr_s = scan_addr_r[AW-1:0];
        end
        if (FLUSH) begin
            fill_next_s = '0;
        end else if (accept_s) begin
            fill_next_s = fill_cnt_r + (AW+1)'(1'b1);
        end else if (deliver_s | expire_s) begin
            fill_next_s = fill_cnt_r - (AW+1)'(1'b1);
        end else begin
            fill_next_s = fill_cnt_r;
        end
    end

    // Command RAM: one write port, registered read port
    always_ff @(posedge CLK) begin
        if (accept_s) begin
            mem_r[free_idx_s] <= {WR_TIME, WR_PAYLOAD};
        end
        rd_data_r <= mem_r[rd_addr_s];
    end

    // SYS_TIME_UPDATE synchroniser and edge history
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sys_sync_r <= 3'b000;
        end else begin
            sys_sync_r <= {sys_sync_r[1:0], SYS_TIME_UPDATE};
        end
    end

    // Scheduler FSM with valid bits, counters and registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            valid_r       <= '0;
            fill_cnt_r    <= '0;
            full_r        <= 1'b0;
            state_r       <= IDLE;
            rescan_pend_r <= 1'b0;
            req_pend_r    <= 1'b0;
            scan_addr_r   <= '0;
            cmp_addr_r    <= '0;
            cmp_en_r      <= 1'b0;
            best_time_r   <= '0;
            best_addr_r   <= '0;
            best_found_r  <= 1'b0;
            cmd_valid_r   <= 1'b0;
            cmd_time_r    <= '0;
            cmd_payload_r <= '0;
            cmd_addr_r    <= '0;
            data_wr_r     <= 1'b0;
            expired_r     <= 1'b0;
        end else begin
            data_wr_r  <= 1'b0;
            expired_r  <= expire_s;
            fill_cnt_r <= fill_next_s;
            full_r     <= (fill_next_s == (AW+1)'(DEPTH));
            if (FLUSH) begin
                valid_r       <= '0;
                cmd_valid_r   <= 1'b0;
                req_pend_r    <= 1'b0;
                rescan_pend_r <= 1'b0;
                cmp_en_r      <= 1'b0;
                state_r       <= IDLE;
            end else begin
                if (REQ_COMM) begin
                    req_pend_r <= 1'b1;
                end
                if (sys_rise_s) begin
                    rescan_pend_r <= 1'b1;
                end
                case (state_r)
                    IDLE: begin
                        if (deliver_s) begin
                            data_wr_r           <= 1'b1;
                            valid_r[cmd_addr_r] <= 1'b0;
                            cmd_valid_r         <= 1'b0;
                            req_pend_r          <= 1'b0;
                            rescan_pend_r       <= 1'b1;
                        end else begin
                            if (accept_s) begin
                                valid_r[free_idx_s] <= 1'b1;
                            end
                            if (go_scan_s) begin
                                // a write taken on this edge is already covered by the scan
                                rescan_pend_r <= sys_rise_s;
                                cmd_valid_r   <= 1'b0;
                                scan_addr_r   <= '0;
                                cmp_en_r      <= 1'b0;
                                best_found_r  <= 1'b0;
                                state_r       <= SCAN;
                            end else if (accept_s) begin
                                rescan_pend_r <= 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        scan_addr_r <= scan_addr_r + (AW+1)'(1'b1);
                        cmp_addr_r  <= scan_addr_r[AW-1:0];
                        cmp_en_r    <= ~scan_addr_r[AW];
                        if (expire_s) begin
                            valid_r[cmp_addr_r] <= 1'b0;
                        end
                        if (better_s) begin
                            best_time_r  <= rd_time_s;
                            best_addr_r  <= cmp_addr_r;
                            best_found_r <= 1'b1;
                        end
                        if (cmp_last_s) begin
                            cmp_en_r <= 1'b0;
                            state_r  <= (best_found_r | cand_s) ? LOAD : IDLE;
                        end
                    end
                    LOAD: begin
                        state_r <= LATCH;
                    end
                    LATCH: begin
                        cmd_time_r    <= rd_time_s;
                        cmd_payload_r <= rd_data_r[PAYLOAD_W-1:0];
                        cmd_addr_r    <= best_addr_r;
                        cmd_valid_r   <= 1'b1;
                        state_r       <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign WR_READY    = wr_ready_s;
    assign DATA_WR     = data_wr_r;
    assign CMD_VALID   = cmd_valid_r;
    assign CMD_TIME    = cmd_time_r;
    assign CMD_PAYLOAD = cmd_payload_r;
    assign CMD_ADDR    = cmd_addr_r;
    assign FILL_CNT    = fill_cnt_r;
    assign FULL        = full_r;
    assign EXPIRED     = expired_r;

endmodule
